// File: rtl/axi_slave_mem_model_if.sv
// AXI4 five-channel bundle between the burst master and the slave memory model.
// The master modport drives AW/W/AR and the B/R ready lines; the slave modport
// drives the ready lines of AW/W/AR and the B/R response channels.
interface axi_slave_mem_model_if #(
  parameter int P_ID_W   = 4,
  parameter int P_ADDR_W = 32,
  parameter int P_DATA_W = 32
);
  localparam int STRB_W = P_DATA_W / 8;

  // write address channel
  logic [P_ID_W-1:0]   s_axi_awid;
  logic [P_ADDR_W-1:0] s_axi_awaddr;
  logic [7:0]          s_axi_awlen;
  logic [2:0]          s_axi_awsize;
  logic [1:0]          s_axi_awburst;
  logic                s_axi_awvalid;
  logic                s_axi_awready;

  // write data channel
  logic [P_DATA_W-1:0] s_axi_wdata;
  logic [STRB_W-1:0]   s_axi_wstrb;
  logic                s_axi_wlast;
  logic                s_axi_wvalid;
  logic                s_axi_wready;

  // write response channel
  logic [P_ID_W-1:0]   s_axi_bid;
  logic [1:0]          s_axi_bresp;
  logic                s_axi_bvalid;
  logic                s_axi_bready;

  // read address channel
  logic [P_ID_W-1:0]   s_axi_arid;
  logic [P_ADDR_W-1:0] s_axi_araddr;
  logic [7:0]          s_axi_arlen;
  logic [2:0]          s_axi_arsize;
  logic [1:0]          s_axi_arburst;
  logic                s_axi_arvalid;
  logic                s_axi_arready;

  // read data channel
  logic [P_ID_W-1:0]   s_axi_rid;
  logic [P_DATA_W-1:0] s_axi_rdata;
  logic [1:0]          s_axi_rresp;
  logic                s_axi_rlast;
  logic                s_axi_rvalid;
  logic                s_axi_rready;

  modport master (
    output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    input  s_axi_wready,
    input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
    output s_axi_bready,
    output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
    input  s_axi_arready,
    input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    output s_axi_rready
  );

  modport slave (
    input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    output s_axi_wready,
    output s_axi_bid, s_axi_bresp, s_axi_bvalid,
    input  s_axi_bready,
    input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
    output s_axi_arready,
    output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    input  s_axi_rready
  );
endinterface

// File: rtl/axi_slave_mem_model.sv
// AXI4 slave memory model: terminates AW/W/B/AR/R, stores INCR/FIXED write
// bursts in a word array and returns them on read bursts. Independent write
// and read FSMs, one outstanding transaction per direction. All outputs are
// registered so they are 0 in the cycle following reset.
// Optional macro AXI_SLV_RAND_STALL_EN: a 16-bit LFSR randomly withholds
// wready/rvalid during data phases to stress the master's flow control.
module axi_slave_mem_model #(
  parameter int P_ID_W      = 4,
  parameter int P_ADDR_W    = 32,
  parameter int P_DATA_W    = 32,
  parameter int P_MEM_DEPTH = 1024
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  axi_slave_mem_model_if.slave s_axi
);

  localparam int IDX_W  = (P_MEM_DEPTH > 1) ? $clog2(P_MEM_DEPTH) : 1;
  localparam int STRB_W = P_DATA_W / 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(P_MEM_DEPTH - 1);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  // word storage; never cleared so contents survive reset
  logic [P_DATA_W-1:0] mem_q [P_MEM_DEPTH];

  // write side state
  w_state_e            w_state_q, w_state_d;
  logic [P_ID_W-1:0]   aw_id_q, aw_id_d;
  logic [IDX_W-1:0]    w_idx_q, w_idx_d;
  logic [7:0]          aw_len_q, aw_len_d;
  logic [7:0]          w_cnt_q, w_cnt_d;
  logic                w_fixed_q, w_fixed_d;
  logic                w_drop_q, w_drop_d;
  logic                awready_q, awready_d;
  logic                wready_q, wready_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                mem_wr_en;
  logic [P_DATA_W-1:0] mem_wr_data;
  logic                w_last_beat;

  // read side state
  r_state_e            r_state_q, r_state_d;
  logic [P_ID_W-1:0]   ar_id_q, ar_id_d;
  logic [IDX_W-1:0]    r_idx_q, r_idx_d;
  logic [7:0]          ar_len_q, ar_len_d;
  logic [7:0]          r_cnt_q, r_cnt_d;
  logic                r_fixed_q, r_fixed_d;
  logic                r_err_q, r_err_d;
  logic                arready_q, arready_d;
  logic                rvalid_q, rvalid_d;
  logic                rlast_q, rlast_d;
  logic [1:0]          rresp_q, rresp_d;
  logic [P_DATA_W-1:0] rdata_q, rdata_d;
  logic [IDX_W-1:0]    r_next_idx;
  logic [IDX_W-1:0]    ar_start_idx;
  logic                ar_err;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic lane_go;
  logic unused_addr_bits;

  // only the word-index field of each address selects storage
  assign unused_addr_bits = ^{s_axi.s_axi_awaddr, s_axi.s_axi_araddr};

  assign aw_hs = awready_q & s_axi.s_axi_awvalid;
  assign w_hs  = wready_q  & s_axi.s_axi_wvalid;
  assign b_hs  = bvalid_q  & s_axi.s_axi_bready;
  assign ar_hs = arready_q & s_axi.s_axi_arvalid;
  assign r_hs  = rvalid_q  & s_axi.s_axi_rready;

  assign s_axi.s_axi_awready = awready_q;
  assign s_axi.s_axi_wready  = wready_q;
  assign s_axi.s_axi_bvalid  = bvalid_q;
  assign s_axi.s_axi_bresp   = bresp_q;
  assign s_axi.s_axi_bid     = aw_id_q;
  assign s_axi.s_axi_arready = arready_q;
  assign s_axi.s_axi_rvalid  = rvalid_q;
  assign s_axi.s_axi_rlast   = rlast_q;
  assign s_axi.s_axi_rresp   = rresp_q;
  assign s_axi.s_axi_rdata   = rdata_q;
  assign s_axi.s_axi_rid     = ar_id_q;

  // INCR advances and wraps at the top of the array; FIXED stays on one word
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx,
                                                input logic             fixed);
    if (fixed) begin
      return idx;
    end else if (idx == LAST_IDX) begin
      return '0;
    end else begin
      return idx + IDX_W'(1);
    end
  endfunction

`ifdef AXI_SLV_RAND_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // maximal-length x^16+x^14+x^13+x^11 shift register stepping every cycle
  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // LFSR register, reseeded on every reset so stall patterns repeat
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // roughly one cycle in four is stalled
  assign lane_go = (lfsr_q[1:0] != 2'b00);
`else
  assign lane_go = 1'b1;
`endif

  // write FSM next state, burst bookkeeping and byte-merged array write
  always_comb begin
    w_state_d   = w_state_q;
    aw_id_d     = aw_id_q;
    w_idx_d     = w_idx_q;
    aw_len_d    = aw_len_q;
    w_cnt_d     = w_cnt_q;
    w_fixed_d   = w_fixed_q;
    w_drop_d    = w_drop_q;
    bresp_d     = bresp_q;
    mem_wr_en   = 1'b0;
    mem_wr_data = mem_q[w_idx_q];
    w_last_beat = (w_cnt_q == aw_len_q);

    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_id_d   = s_axi.s_axi_awid;
          w_idx_d   = s_axi.s_axi_awaddr[2 +: IDX_W];
          aw_len_d  = s_axi.s_axi_awlen;
          w_cnt_d   = 8'd0;
          w_fixed_d = (s_axi.s_axi_awburst == 2'b00);
          w_drop_d  = (s_axi.s_axi_awsize != 3'b010) || s_axi.s_axi_awburst[1];
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          if (!w_drop_q) begin
            mem_wr_en = 1'b1;
            for (int b = 0; b < STRB_W; b++) begin
              if (s_axi.s_axi_wstrb[b]) begin
                mem_wr_data[8*b +: 8] = s_axi.s_axi_wdata[8*b +: 8];
              end
            end
          end
          w_cnt_d = w_cnt_q + 8'd1;
          w_idx_d = next_idx(w_idx_q, w_fixed_q);
          if (w_last_beat || s_axi.s_axi_wlast) begin
            w_state_d = W_RESP;
            bresp_d   = (w_drop_q || (w_last_beat != s_axi.s_axi_wlast)) ? 2'b10 : 2'b00;
          end
        end
      end
      W_RESP: begin
        if (b_hs) begin
          w_state_d = W_IDLE;
        end
      end
      default: begin
        w_state_d = W_IDLE;
      end
    endcase

    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA) && lane_go;
    bvalid_d  = (w_state_d == W_RESP);
  end

  // write FSM and write-channel output registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      w_state_q <= W_IDLE;
      aw_id_q   <= '0;
      w_idx_q   <= '0;
      aw_len_q  <= '0;
      w_cnt_q   <= '0;
      w_fixed_q <= 1'b0;
      w_drop_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      w_state_q <= w_state_d;
      aw_id_q   <= aw_id_d;
      w_idx_q   <= w_idx_d;
      aw_len_q  <= aw_len_d;
      w_cnt_q   <= w_cnt_d;
      w_fixed_q <= w_fixed_d;
      w_drop_q  <= w_drop_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // array write port; a beat landing on a reset edge is discarded with the burst
  always_ff @(posedge i_clk) begin
    if (mem_wr_en && i_rst_n) begin
      mem_q[w_idx_q] <= mem_wr_data;
    end
  end

  // read FSM next state; rdata is fetched at the edge that presents each beat
  always_comb begin
    r_state_d    = r_state_q;
    ar_id_d      = ar_id_q;
    r_idx_d      = r_idx_q;
    ar_len_d     = ar_len_q;
    r_cnt_d      = r_cnt_q;
    r_fixed_d    = r_fixed_q;
    r_err_d      = r_err_q;
    rlast_d      = rlast_q;
    rresp_d      = rresp_q;
    rdata_d      = rdata_q;
    r_next_idx   = next_idx(r_idx_q, r_fixed_q);
    ar_start_idx = s_axi.s_axi_araddr[2 +: IDX_W];
    ar_err       = (s_axi.s_axi_arsize != 3'b010) || s_axi.s_axi_arburst[1];

    unique case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          ar_id_d   = s_axi.s_axi_arid;
          r_idx_d   = ar_start_idx;
          ar_len_d  = s_axi.s_axi_arlen;
          r_cnt_d   = 8'd0;
          r_fixed_d = (s_axi.s_axi_arburst == 2'b00);
          r_err_d   = ar_err;
          rdata_d   = ar_err ? '0 : mem_q[ar_start_idx];
          rlast_d   = (s_axi.s_axi_arlen == 8'd0);
          rresp_d   = ar_err ? 2'b10 : 2'b00;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (r_hs) begin
          if (r_cnt_q == ar_len_q) begin
            r_state_d = R_IDLE;
          end else begin
            r_idx_d = r_next_idx;
            r_cnt_d = r_cnt_q + 8'd1;
            rdata_d = r_err_q ? '0 : mem_q[r_next_idx];
            rlast_d = ((r_cnt_q + 8'd1) == ar_len_q);
          end
        end
      end
    endcase

    arready_d = (r_state_d == R_IDLE);
    if (r_state_d == R_DATA) begin
      rvalid_d = (rvalid_q && !r_hs) || lane_go;
    end else begin
      rvalid_d = 1'b0;
    end
  end

  // read FSM and read-channel output registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state_q <= R_IDLE;
      ar_id_q   <= '0;
      r_idx_q   <= '0;
      ar_len_q  <= '0;
      r_cnt_q   <= '0;
      r_fixed_q <= 1'b0;
      r_err_q   <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      ar_id_q   <= ar_id_d;
      r_idx_q   <= r_idx_d;
      ar_len_q  <= ar_len_d;
      r_cnt_q   <= r_cnt_d;
      r_fixed_q <= r_fixed_d;
      r_err_q   <= r_err_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

endmodule

// File: tb/tb_axi_slave_mem_model.sv
// Directed bench for axi_slave_mem_model: write/readback bursts, B back-pressure,
// array wrap, early wlast, unsupported size/burst, FIXED with byte strobes,
// and reset in the middle of a write burst. Inputs change on the falling edge
// or just after the rising edge; outputs are sampled on the falling edge.
module tb_axi_slave_mem_model;

  localparam int LIMIT = 200;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  axi_slave_mem_model_if #(.P_ID_W(4), .P_ADDR_W(32), .P_DATA_W(32)) bus ();

  axi_slave_mem_model #(
    .P_ID_W(4), .P_ADDR_W(32), .P_DATA_W(32), .P_MEM_DEPTH(1024)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .s_axi(bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] wVec [16];
  logic [3:0]  sVec [16];
  logic [31:0] eVec [16];

  // single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // park every master-driven line
  task automatic driveIdle();
    bus.s_axi_awid = '0; bus.s_axi_awaddr = '0; bus.s_axi_awlen = '0;
    bus.s_axi_awsize = 3'b010; bus.s_axi_awburst = 2'b01; bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wlast = 1'b0; bus.s_axi_wvalid = 1'b0;
    bus.s_axi_bready = 1'b0;
    bus.s_axi_arid = '0; bus.s_axi_araddr = '0; bus.s_axi_arlen = '0;
    bus.s_axi_arsize = 3'b010; bus.s_axi_arburst = 2'b01; bus.s_axi_arvalid = 1'b0;
    bus.s_axi_rready = 1'b0;
  endtask

  task automatic sendAw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                        input logic [1:0] burst, input logic [2:0] size);
    int n = 0;
    @(negedge clk);
    bus.s_axi_awid = id; bus.s_axi_awaddr = addr; bus.s_axi_awlen = len;
    bus.s_axi_awburst = burst; bus.s_axi_awsize = size; bus.s_axi_awvalid = 1'b1;
    while (!bus.s_axi_awready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_axi_awready) checkOutput("aw_wait", 32'(bus.s_axi_awready), 32'd1);
    @(posedge clk);
    #1 bus.s_axi_awvalid = 1'b0;
  endtask

  task automatic sendW(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    @(negedge clk);
    bus.s_axi_wdata = data; bus.s_axi_wstrb = strb; bus.s_axi_wlast = last;
    bus.s_axi_wvalid = 1'b1;
    while (!bus.s_axi_wready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_axi_wready) checkOutput("w_wait", 32'(bus.s_axi_wready), 32'd1);
    @(posedge clk);
    #1 bus.s_axi_wvalid = 1'b0;
    bus.s_axi_wlast = 1'b0;
  endtask

  // wait for B, optionally hold bready low while a second AW is offered
  task automatic recvB(input logic [3:0] expId, input logic [1:0] expResp, input int delay);
    int n = 0;
    @(negedge clk);
    while (!bus.s_axi_bvalid && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    checkOutput("b_valid", 32'(bus.s_axi_bvalid), 32'd1);
    checkOutput("b_resp", 32'(bus.s_axi_bresp), 32'(expResp));
    checkOutput("b_id", 32'(bus.s_axi_bid), 32'(expId));
    checkOutput("w_closed", 32'(bus.s_axi_wready), 32'd0);
    if (delay > 0) begin
      bus.s_axi_awvalid = 1'b1;
      for (int i = 0; i < delay; i++) begin
        @(negedge clk);
        checkOutput("b_hold_valid", 32'(bus.s_axi_bvalid), 32'd1);
        checkOutput("b_hold_id", 32'(bus.s_axi_bid), 32'(expId));
        checkOutput("aw_blocked", 32'(bus.s_axi_awready), 32'd0);
      end
      bus.s_axi_awvalid = 1'b0;
    end
    bus.s_axi_bready = 1'b1;
    @(posedge clk);
    #1 bus.s_axi_bready = 1'b0;
    @(negedge clk);
    checkOutput("b_done", 32'(bus.s_axi_bvalid), 32'd0);
    checkOutput("aw_reopen", 32'(bus.s_axi_awready), 32'd1);
  endtask

  task automatic writeBurst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] burst, input logic [2:0] size, input int nBeats,
                            input int lastBeat, input logic [1:0] expResp, input int bDelay);
    sendAw(id, addr, len, burst, size);
    for (int i = 0; i < nBeats; i++) sendW(wVec[i], sVec[i], (i == lastBeat));
    recvB(id, expResp, bDelay);
  endtask

  // issue AR and collect beats against eVec; toggle throttles rready
  task automatic readBurst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [1:0] expResp, input logic toggle);
    int n = 0;
    int beats = 0;
    int cyc = 0;
    logic stalled = 1'b0;
    logic [31:0] held = '0;
    @(negedge clk);
    bus.s_axi_arid = id; bus.s_axi_araddr = addr; bus.s_axi_arlen = len;
    bus.s_axi_arsize = size; bus.s_axi_arburst = burst; bus.s_axi_arvalid = 1'b1;
    while (!bus.s_axi_arready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_axi_arready) checkOutput("ar_wait", 32'(bus.s_axi_arready), 32'd1);
    @(posedge clk);
    #1 bus.s_axi_arvalid = 1'b0;
    while (beats <= int'(len) && cyc < LIMIT) begin
      @(negedge clk);
      bus.s_axi_rready = (toggle && (cyc % 3 == 1)) ? 1'b0 : 1'b1;
      if (stalled) begin
        checkOutput("r_hold_valid", 32'(bus.s_axi_rvalid), 32'd1);
        checkOutput("r_hold_data", bus.s_axi_rdata, held);
      end
      if (bus.s_axi_rvalid && bus.s_axi_rready) begin
        checkOutput("r_data", bus.s_axi_rdata, eVec[beats]);
        checkOutput("r_last", 32'(bus.s_axi_rlast), 32'(beats == int'(len)));
        checkOutput("r_resp", 32'(bus.s_axi_rresp), 32'(expResp));
        checkOutput("r_id", 32'(bus.s_axi_rid), 32'(id));
        beats++;
        stalled = 1'b0;
      end else if (bus.s_axi_rvalid) begin
        stalled = 1'b1;
        held = bus.s_axi_rdata;
      end
      cyc++;
    end
    @(posedge clk);
    #1 bus.s_axi_rready = 1'b0;
    checkOutput("r_beats", 32'(beats), 32'(len) + 32'd1);
    @(negedge clk);
    checkOutput("r_done", 32'(bus.s_axi_rvalid), 32'd0);
    checkOutput("ar_reopen", 32'(bus.s_axi_arready), 32'd1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_awready"}, 32'(bus.s_axi_awready), 32'd0);
    checkOutput({tag, "_wready"}, 32'(bus.s_axi_wready), 32'd0);
    checkOutput({tag, "_bvalid"}, 32'(bus.s_axi_bvalid), 32'd0);
    checkOutput({tag, "_arready"}, 32'(bus.s_axi_arready), 32'd0);
    checkOutput({tag, "_rvalid"}, 32'(bus.s_axi_rvalid), 32'd0);
    checkOutput({tag, "_rlast"}, 32'(bus.s_axi_rlast), 32'd0);
  endtask

  // full directed sequence
  task automatic applyStimulus();
    rst_n = 1'b0;
    driveIdle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAllZero("rst");
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_awready", 32'(bus.s_axi_awready), 32'd1);
    checkOutput("rst_arready", 32'(bus.s_axi_arready), 32'd1);

    $display("[TB] 16-beat INCR write and readback");
    for (int i = 0; i < 16; i++) begin wVec[i] = 32'(i); sVec[i] = 4'hF; eVec[i] = 32'(i); end
    writeBurst(4'h3, 32'h0, 8'd15, 2'b01, 3'b010, 16, 15, 2'b00, 0);
    readBurst(4'h5, 32'h0, 8'd15, 3'b010, 2'b01, 2'b00, 1'b1);

    $display("[TB] B back-pressure");
    wVec[0] = 32'h9000_0000; wVec[1] = 32'h9000_0001;
    writeBurst(4'h9, 32'h40, 8'd1, 2'b01, 3'b010, 2, 1, 2'b00, 5);

    $display("[TB] wrap at top of array");
    wVec[0] = 32'hA5A5_000A; wVec[1] = 32'hA5A5_000B;
    wVec[2] = 32'hA5A5_000C; wVec[3] = 32'hA5A5_000D;
    for (int i = 0; i < 4; i++) begin sVec[i] = 4'hF; eVec[i] = wVec[i]; end
    writeBurst(4'h1, 32'hFF8, 8'd3, 2'b01, 3'b010, 4, 3, 2'b00, 0);
    readBurst(4'h2, 32'hFF8, 8'd3, 3'b010, 2'b01, 2'b00, 1'b0);
    eVec[0] = 32'hA5A5_000C; eVec[1] = 32'hA5A5_000D;
    readBurst(4'h3, 32'h0, 8'd1, 3'b010, 2'b01, 2'b00, 1'b0);

    $display("[TB] early wlast and unsupported read size");
    for (int i = 0; i < 4; i++) begin wVec[i] = 32'h3000 + 32'(i); sVec[i] = 4'hF; end
    writeBurst(4'h8, 32'h320, 8'd7, 2'b01, 3'b010, 4, 3, 2'b10, 0);
    eVec[0] = 32'h0; eVec[1] = 32'h0;
    readBurst(4'hA, 32'h320, 8'd1, 3'b001, 2'b01, 2'b10, 1'b0);
    for (int i = 0; i < 4; i++) eVec[i] = 32'h3000 + 32'(i);
    readBurst(4'hB, 32'h320, 8'd3, 3'b010, 2'b01, 2'b00, 1'b0);

    $display("[TB] FIXED burst with strobes, unsupported write burst");
    wVec[0] = 32'h1111_1111; sVec[0] = 4'hF;
    wVec[1] = 32'h2222_2222; sVec[1] = 4'h3;
    writeBurst(4'h4, 32'h4B0, 8'd1, 2'b00, 3'b010, 2, 1, 2'b00, 0);
    eVec[0] = 32'h1111_2222;
    readBurst(4'h6, 32'h4B0, 8'd0, 3'b010, 2'b01, 2'b00, 1'b0);
    wVec[0] = 32'hDEAD_BEEF; sVec[0] = 4'hF;
    writeBurst(4'h7, 32'h4B0, 8'd0, 2'b10, 3'b010, 1, 0, 2'b10, 0);
    readBurst(4'h6, 32'h4B0, 8'd0, 3'b010, 2'b01, 2'b00, 1'b0);

    $display("[TB] reset in the middle of a write burst");
    sendAw(4'h2, 32'h100, 8'd7, 2'b01, 3'b010);
    for (int i = 0; i < 5; i++) sendW(32'h500 + 32'(i), 4'hF, 1'b0);
    @(negedge clk);
    bus.s_axi_wdata = 32'h505; bus.s_axi_wstrb = 4'hF; bus.s_axi_wvalid = 1'b1;
    rst_n = 1'b0;
    @(posedge clk);
    #1 bus.s_axi_wvalid = 1'b0;
    @(negedge clk);
    checkAllZero("midrst");
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_aw_back", 32'(bus.s_axi_awready), 32'd1);
    wVec[0] = 32'h6000_0000; wVec[1] = 32'h6000_0001; sVec[0] = 4'hF; sVec[1] = 4'hF;
    writeBurst(4'hC, 32'h180, 8'd1, 2'b01, 3'b010, 2, 1, 2'b00, 0);
    for (int i = 0; i < 5; i++) eVec[i] = 32'h500 + 32'(i);
    readBurst(4'hD, 32'h100, 8'd4, 3'b010, 2'b01, 2'b00, 1'b1);
    eVec[0] = 32'h6000_0000; eVec[1] = 32'h6000_0001;
    readBurst(4'hE, 32'h180, 8'd1, 3'b010, 2'b01, 2'b00, 1'b0);
    eVec[0] = 32'hA5A5_000C; eVec[1] = 32'hA5A5_000D;
    readBurst(4'hF, 32'h0, 8'd1, 3'b010, 2'b01, 2'b00, 1'b0);
  endtask

  initial begin
    applyStimulus();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // absolute time bound in case a handshake never completes
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
